// File: rtl/codec_init_sequencer_if.sv
// Signal bundle between the PS/AXI control side, codec_init_sequencer and
// codec_unit_top. The sequencer connects through the slave modport; the
// environment that starts it and the codec side use the master modport.
interface codec_init_sequencer_if;
    logic       start;
    logic [4:0] freq_sel;
    logic       pll_locked;
    logic       controller_busy;
    logic [7:0] codec_data_out;
    logic       codec_wr_en;
    logic       codec_rd_en;
    logic [6:0] codec_reg_addr;
    logic [7:0] codec_data_in;
    logic [4:0] frequency;
    logic       apply_config;
    logic       output_en;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] err_index;

    modport master (
        output start, freq_sel, pll_locked, controller_busy, codec_data_out,
        input  codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in, frequency,
               apply_config, output_en, busy, done, error, err_index
    );

    modport slave (
        input  start, freq_sel, pll_locked, controller_busy, codec_data_out,
        output codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in, frequency,
               apply_config, output_en, busy, done, error, err_index
    );
endinterface

// File: rtl/codec_init_sequencer.sv
// Boot-time sequencer for codec_unit_top: waits for PLL lock, writes the
// INIT_TABLE entries through the codec register port (paced on
// controller_busy, with per-entry retry on timeout), then pulses apply_config
// and enables the output.
// Optional feature macro: CODEC_READBACK_EN -- reads every entry back after
// its write and re-writes it on mismatch.
//
// state          | meaning
// S_IDLE         | after reset, nothing started
// S_WAIT_LOCK    | waiting for pll_locked (timed)
// S_ISSUE        | present entry[index], one-cycle write request
// S_WAIT_ACK     | waiting for controller_busy to rise (timed)
// S_WAIT_DONE    | waiting for controller_busy to fall (timed)
// S_RD_ISSUE     | one-cycle read request of the same address (readback)
// S_RD_WAIT_ACK  | waiting for read to start (readback, timed)
// S_RD_WAIT_DONE | waiting for read to finish (readback, timed)
// S_CHECK        | compare readback data with table data (readback)
// S_NEXT         | advance index or finish
// S_APPLY        | one-cycle apply_config pulse
// S_DONE         | sequence complete, output enabled
// S_ERROR        | lock timeout or retries exhausted
module codec_init_sequencer #(
    parameter int unsigned              NUM_REGS       = 11,
    parameter logic [15*NUM_REGS-1:0]   INIT_TABLE     = '0,
    parameter int unsigned              TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned              MAX_RETRY      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    codec_init_sequencer_if.slave bus
);

    localparam int unsigned    TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMR_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     RETRY_MAX = 3'(MAX_RETRY);
    localparam logic [7:0]     LAST_IDX  = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_LOCK, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_NEXT, S_APPLY,
        S_DONE, S_ERROR, S_RD_ISSUE, S_RD_WAIT_ACK, S_RD_WAIT_DONE, S_CHECK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_index;
    logic [7:0]      w_index_nxt;
    logic [2:0]      r_retry;
    logic [2:0]      w_retry_nxt;
    logic [7:0]      r_err_index;
    logic [7:0]      w_err_nxt;
    logic [4:0]      r_frequency;
    logic [4:0]      w_freq_nxt;
    logic [TW-1:0]   r_timer;
    logic            w_timeout;
    logic            w_retry_fail;
    logic [14:0]     w_entry;
    logic            w_hold;

    assign w_entry   = INIT_TABLE[15*r_index +: 15];
    assign w_timeout = (r_timer == '0);
    // Address/data stay on the port for the whole transaction of an entry.
    assign w_hold    = r_state inside {S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_NEXT,
                                       S_RD_ISSUE, S_RD_WAIT_ACK, S_RD_WAIT_DONE, S_CHECK};

`ifndef CODEC_READBACK_EN
    logic w_unused_rd_data;
    assign w_unused_rd_data = ^bus.codec_data_out;
`endif

    // State and sequencing registers; the shared timeout counter reloads on every state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_retry     <= '0;
            r_err_index <= '0;
            r_frequency <= '0;
            r_timer     <= TMR_LOAD;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_retry     <= w_retry_nxt;
            r_err_index <= w_err_nxt;
            r_frequency <= w_freq_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= TMR_LOAD;
            end else if (!w_timeout) begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_retry_nxt  = r_retry;
        w_err_nxt    = r_err_index;
        w_freq_nxt   = r_frequency;
        w_retry_fail = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_index_nxt = '0;
                    w_retry_nxt = '0;
                    w_freq_nxt  = bus.freq_sel;
                end
            end
            S_WAIT_LOCK: begin
                if (bus.pll_locked) begin
                    w_state_nxt = S_ISSUE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = 8'hFF;
                end
            end
            // A codec already busy here is taken as the acknowledge.
            S_ISSUE: w_state_nxt = bus.controller_busy ? S_WAIT_DONE : S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (bus.controller_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_retry_fail = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.controller_busy) begin
`ifdef CODEC_READBACK_EN
                    w_state_nxt = S_RD_ISSUE;
`else
                    w_state_nxt = S_NEXT;
`endif
                end else if (w_timeout) begin
                    w_retry_fail = 1'b1;
                end
            end
`ifdef CODEC_READBACK_EN
            S_RD_ISSUE: w_state_nxt = bus.controller_busy ? S_RD_WAIT_DONE : S_RD_WAIT_ACK;
            S_RD_WAIT_ACK: begin
                if (bus.controller_busy) begin
                    w_state_nxt = S_RD_WAIT_DONE;
                end else if (w_timeout) begin
                    w_retry_fail = 1'b1;
                end
            end
            S_RD_WAIT_DONE: begin
                if (!bus.controller_busy) begin
                    w_state_nxt = S_CHECK;
                end else if (w_timeout) begin
                    w_retry_fail = 1'b1;
                end
            end
            S_CHECK: begin
                if (bus.codec_data_out == w_entry[7:0]) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_retry_fail = 1'b1;
                end
            end
`endif
            S_NEXT: begin
                if (r_index == LAST_IDX) begin
                    w_state_nxt = S_APPLY;
                end else begin
                    w_index_nxt = r_index + 8'd1;
                    w_retry_nxt = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_APPLY: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_retry_fail) begin
            if (r_retry < RETRY_MAX) begin
                w_retry_nxt = r_retry + 3'd1;
                w_state_nxt = S_ISSUE;
            end else begin
                w_state_nxt = S_ERROR;
                w_err_nxt   = r_index;
            end
        end
    end

    // Outputs decoded from the current state so an async reset clears them at once.
    always_comb begin
        bus.codec_wr_en    = (r_state == S_ISSUE) && !bus.controller_busy;
`ifdef CODEC_READBACK_EN
        bus.codec_rd_en    = (r_state == S_RD_ISSUE) && !bus.controller_busy;
`else
        bus.codec_rd_en    = 1'b0;
`endif
        bus.codec_reg_addr = w_hold ? w_entry[14:8] : 7'd0;
        bus.codec_data_in  = w_hold ? w_entry[7:0] : 8'd0;
        bus.frequency      = r_frequency;
        bus.apply_config   = (r_state == S_APPLY);
        bus.output_en      = (r_state == S_DONE);
        bus.done           = (r_state == S_DONE);
        bus.error          = (r_state == S_ERROR);
        bus.busy           = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
        bus.err_index      = (r_state == S_ERROR) ? r_err_index : 8'd0;
    end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Testbench for codec_init_sequencer: 3-entry table, 100-cycle timeout,
// 2 retries. A codec responder raises controller_busy 3 cycles after each
// write request for 40 cycles; a scoreboard of expected entry indices checks
// every write, plus per-test literal expectations.
module tb_codec_init_sequencer;

    localparam logic [44:0] TBL = {7'h07, 8'h02, 7'h06, 8'h10, 7'h0F, 8'h00};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    codec_init_sequencer_if bus ();

    codec_init_sequencer #(
        .NUM_REGS(3), .INIT_TABLE(TBL), .TIMEOUT_CYCLES(100), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    logic [6:0] m_addr [3] = '{7'h0F, 7'h06, 7'h07};
    logic [7:0] m_data [3] = '{8'h00, 8'h10, 8'h02};

    int         exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_wr = 0;
    int         n_apply = 0;
    logic [4:0] exp_freq = 5'h00;
    logic [7:0] exp_err = 8'h00;
    logic [6:0] last_addr = 7'h00;
    logic [7:0] last_data = 8'h00;
    logic [6:0] mute_addr = 7'h7F;
    int         busy_len = 40;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // codec model: busy rises 3 cycles after a write request, stays high busy_len cycles
    initial begin : responder
        int d;
        int b;
        d = 0;
        b = 0;
        bus.controller_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                d = 0;
                b = 0;
                bus.controller_busy = 1'b0;
            end else if (b > 0) begin
                b--;
                if (b == 0) bus.controller_busy = 1'b0;
            end else if (d > 0) begin
                d--;
                if (d == 0) begin
                    bus.controller_busy = 1'b1;
                    b = busy_len;
                end
            end else if (bus.codec_wr_en && bus.codec_reg_addr != mute_addr) begin
                d = 3;
            end
        end
    end

    // per-cycle compare against the scoreboard and the sequencing rules
    initial begin : compare
        logic prev_wr;
        logic prev_apply;
        int   idx;
        prev_wr = 1'b0;
        prev_apply = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_wr = 1'b0;
                prev_apply = 1'b0;
            end else begin
                chk("status_onehot", 32'($countones({bus.busy, bus.done, bus.error}) <= 1), 1);
                if (bus.busy || bus.error) chk("output_en_off", bus.output_en, 0);
`ifndef CODEC_READBACK_EN
                chk("rd_en_never", bus.codec_rd_en, 0);
`endif
                if (bus.codec_wr_en) begin
                    chk("wr_single_cycle", prev_wr, 0);
                    chk("wr_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        idx = exp_q.pop_front();
                        chk("wr_addr", bus.codec_reg_addr, m_addr[idx]);
                        chk("wr_data", bus.codec_data_in, m_data[idx]);
                    end
                    last_addr = bus.codec_reg_addr;
                    last_data = bus.codec_data_in;
                    n_wr++;
                end
                if (bus.apply_config) begin
                    chk("apply_single_cycle", prev_apply, 0);
                    chk("apply_after_all_writes", exp_q.size(), 0);
                    n_apply++;
                end
                if (bus.controller_busy && bus.busy) begin
                    chk("addr_stable", bus.codec_reg_addr, last_addr);
                    chk("data_stable", bus.codec_data_in, last_data);
                end
                if (bus.busy || bus.done || bus.error) chk("frequency", bus.frequency, exp_freq);
                if (bus.error) chk("err_index", bus.err_index, exp_err);
                prev_wr = bus.codec_wr_en;
                prev_apply = bus.apply_config;
            end
        end
    end

    task automatic pulse_start(input logic [4:0] f, input bit upd);
        @(negedge clk);
        bus.start = 1'b1;
        bus.freq_sel = f;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (upd) exp_freq = f;
    endtask

    task automatic wait_end(input int max, input string name);
        int k = 0;
        while (!(bus.done || bus.error) && k < max) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_terminates"}, 32'(bus.done || bus.error), 1);
    endtask

    task automatic wait_writes(input int n, input int max);
        int k = 0;
        while (n_wr < n && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("writes_reached", n_wr, n);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int k_err;
        bus.start = 1'b0;
        bus.freq_sel = 5'h00;
        bus.pll_locked = 1'b0;
        bus.codec_data_out = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_wr_en", bus.codec_wr_en, 0);
        chk("rst_frequency", bus.frequency, 0);
        chk("rst_output_en", bus.output_en, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // T1: full sequence, lock 20 cycles after start
        exp_q = '{0, 1, 2};
        n_wr = 0;
        n_apply = 0;
        pulse_start(5'h03, 1);
        chk("t1_busy_after_start", bus.busy, 1);
        repeat (20) @(negedge clk);
        chk("t1_no_write_before_lock", n_wr, 0);
        bus.pll_locked = 1'b1;
        wait_end(1000, "t1");
        chk("t1_writes", n_wr, 3);
        chk("t1_applies", n_apply, 1);
        chk("t1_done", bus.done, 1);
        chk("t1_output_en", bus.output_en, 1);
        chk("t1_frequency", bus.frequency, 5'h03);
        chk("t1_busy_low", bus.busy, 0);

        // T2: lock never arrives -> error exactly 100 cycles after the start edge
        bus.pll_locked = 1'b0;
        n_wr = 0;
        n_apply = 0;
        pulse_start(5'h1F, 1);
        exp_err = 8'hFF;
        chk("t2_done_cleared", bus.done, 0);
        k_err = 0;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (bus.error) begin
                k_err = k;
                break;
            end
        end
        chk("t2_error_cycle", k_err, 100);
        chk("t2_err_index", bus.err_index, 8'hFF);
        @(negedge clk);
        chk("t2_no_writes", n_wr, 0);

        // T3: entry 1 never acknowledged -> written 3 times, then error index 1
        bus.pll_locked = 1'b1;
        mute_addr = 7'h06;
        exp_q = '{0, 1, 1, 1};
        n_wr = 0;
        n_apply = 0;
        pulse_start(5'h03, 1);
        exp_err = 8'h01;
        wait_end(2000, "t3");
        chk("t3_error", bus.error, 1);
        chk("t3_err_index", bus.err_index, 8'h01);
        chk("t3_writes", n_wr, 4);
        chk("t3_applies", n_apply, 0);
        mute_addr = 7'h7F;

        // T4: reset during WAIT_DONE of entry 2, then restart from entry 0
        exp_q = '{0, 1, 2};
        n_wr = 0;
        n_apply = 0;
        pulse_start(5'h03, 1);
        wait_writes(3, 1000);
        repeat (10) @(negedge clk);
        chk("t4_in_sequence", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_busy", bus.busy, 0);
        chk("t4_rst_wr_en", bus.codec_wr_en, 0);
        chk("t4_rst_apply", bus.apply_config, 0);
        chk("t4_rst_addr", bus.codec_reg_addr, 0);
        chk("t4_rst_data", bus.codec_data_in, 0);
        chk("t4_rst_frequency", bus.frequency, 0);
        chk("t4_rst_flags", {bus.done, bus.error, bus.output_en}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q = '{0, 1, 2};
        n_wr = 0;
        n_apply = 0;
        pulse_start(5'h03, 1);
        wait_end(1000, "t4");
        chk("t4_writes", n_wr, 3);
        chk("t4_done", bus.done, 1);

        // T5: start while busy is ignored; start after done reruns everything
        exp_q = '{0, 1, 2};
        n_wr = 0;
        n_apply = 0;
        pulse_start(5'h03, 1);
        wait_writes(1, 500);
        pulse_start(5'h11, 0);
        chk("t5_ignored_busy", bus.busy, 1);
        wait_end(1000, "t5a");
        chk("t5a_writes", n_wr, 3);
        chk("t5a_applies", n_apply, 1);
        chk("t5a_frequency", bus.frequency, 5'h03);
        exp_q = '{0, 1, 2};
        n_wr = 0;
        n_apply = 0;
        pulse_start(5'h07, 1);
        chk("t5_done_cleared", bus.done, 0);
        chk("t5_output_en_cleared", bus.output_en, 0);
        chk("t5_busy", bus.busy, 1);
        wait_end(1000, "t5b");
        chk("t5b_writes", n_wr, 3);
        chk("t5b_applies", n_apply, 1);
        chk("t5b_output_en", bus.output_en, 1);
        chk("t5b_frequency", bus.frequency, 5'h07);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
